// File: rtl/char_arb_pkg.sv
// char_arb_pkg: shared FSM state type, default terminator and index-width helper for the char arbiter
package char_arb_pkg;
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [7:0] TERM_CHAR_DEF = 8'h00;
  function automatic int SRC_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/char_msg_arbiter_if.sv
// char_msg_arbiter_if: source/sink character handshake bundle
//   master: arbiter view (drives readies and the sink side)
//   slave : environment view (drives sources, enable and sink ready)
//   _enable          allow new grants
//   _src_valid/_src_char/_src_ready   per-source handshake, chars packed CHAR_W each
//   _out_valid/_out_ready/_out_char   sink handshake
//   _out_src/_out_last/_trunc         granted index, message end, forced-close pulse
interface char_msg_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int CHAR_W = 8
);
  import char_arb_pkg::*;
  localparam int IW = SRC_IDX_W(N_SRC);
  logic                    _enable;
  logic [N_SRC-1:0]        _src_valid;
  logic [N_SRC*CHAR_W-1:0] _src_char;
  logic [N_SRC-1:0]        _src_ready;
  logic                    _out_valid;
  logic                    _out_ready;
  logic [CHAR_W-1:0]       _out_char;
  logic [IW-1:0]           _out_src;
  logic                    _out_last;
  logic                    _trunc;
  modport master (
    input  _enable, _src_valid, _src_char, _out_ready,
    output _src_ready, _out_valid, _out_char, _out_src, _out_last, _trunc
  );
  modport slave (
    output _enable, _src_valid, _src_char, _out_ready,
    input  _src_ready, _out_valid, _out_char, _out_src, _out_last, _trunc
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker
//   req     request vector
//   ptr     highest-priority index this round
//   gnt_idx first requester at or after ptr (mod N)
//   any     at least one request
module rr_pick
  import char_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = SRC_IDX_W(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  localparam logic [IW:0] NV = (IW+1)'(N);
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  // rotate so ptr sits at bit 0, encode lowest set bit, then rotate the index back
  assign rot = N'({req, req} >> ptr);
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = IW'(i);
  end
  assign sum     = {1'b0, off} + {1'b0, ptr};
  assign gnt_idx = (sum >= NV) ? IW'(sum - NV) : IW'(sum);
  assign any     = |req;
endmodule

// File: rtl/char_msg_arbiter.sv
// char_msg_arbiter: message-level round-robin arbiter sharing one char sink among N_SRC sources
//   _clock  rising-edge clock
//   _reset  synchronous active-low reset
//   bus     char_msg_arbiter_if.master (enable, source handshakes, sink handshake, status)
module char_msg_arbiter
  import char_arb_pkg::*;
#(
  parameter int              N_SRC     = 4,
  parameter int              CHAR_W    = 8,
  parameter logic [CHAR_W-1:0] TERM_CHAR = CHAR_W'(TERM_CHAR_DEF),
  parameter int              MAX_LEN   = 64
) (
  input logic                 _clock,
  input logic                 _reset,
  char_msg_arbiter_if.master  bus
);
  localparam int IW = SRC_IDX_W(N_SRC);
  localparam int CW = $clog2(MAX_LEN) + 1;
  state_t            state, state_nxt;
  logic [IW-1:0]     rr_ptr, g, pick;
  logic [CW-1:0]     count;
  logic [CHAR_W-1:0] chars [N_SRC];
  logic              any, grant, xfer, close, trunc_q;
  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign chars[i] = bus._src_char[i*CHAR_W +: CHAR_W];
  end
  rr_pick #(.N(N_SRC)) u_pick (
    .req     (bus._src_valid),
    .ptr     (rr_ptr),
    .gnt_idx (pick),
    .any     (any)
  );
  // the granted source is passed straight through; everything is gated off in IDLE
  always_comb begin
    bus._out_valid = (state == STREAM) & bus._src_valid[g];
    bus._out_char  = (state == STREAM) ? chars[g] : '0;
    bus._src_ready = (state == STREAM && bus._out_ready) ? (N_SRC'(1) << g) : '0;
    bus._out_last  = bus._out_valid & ((bus._out_char == TERM_CHAR) | (count == CW'(MAX_LEN - 1)));
    xfer           = bus._out_valid & bus._out_ready;
    close          = xfer & bus._out_last;
    grant          = (state == IDLE) & bus._enable & any;
    state_nxt      = grant ? STREAM : close ? IDLE : state;
  end
  assign bus._out_src = (state == STREAM) ? g : '0;
  assign bus._trunc   = trunc_q;
  always_ff @(posedge _clock) begin
    if (!_reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      g       <= '0;
      count   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      trunc_q <= close & (bus._out_char != TERM_CHAR);
      if (grant) begin
        g     <= pick;
        count <= '0;
      end else if (xfer) count <= count + CW'(1);
      // next search starts just past the source that finished
      if (close) rr_ptr <= (g == IW'(N_SRC - 1)) ? '0 : g + IW'(1);
    end
  end
endmodule
